router_1x3: RTL and testbench
=============================

Name: router_1x3

Overview:
- Single-input, three-output packet router.
- Accepts byte-serial packets on `data_in` and steers each packet into one of three 16-deep output FIFOs, selected by the 2-bit address in the header.
- Each destination drains its own FIFO with `read_enb_x` / `valid_out_x` / `data_out_x`.
- Flags parity errors and applies backpressure to the source through `busy`.

Parameters:
- FIFO_DEPTH, 16, entries per output FIFO; must be a power of 2.
- TIMEOUT, 30, consecutive unread cycles before a destination FIFO is soft-reset.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- pkt_valid  input  1  high on header/payload bytes; low on the parity byte.
- data_in  input  8  packet byte stream.
- read_enb_0/1/2  input  1 each  destination read request.
- data_out_0/1/2  output  8 each  registered FIFO read data.
- valid_out_0/1/2  output  1 each  FIFO x non-empty.
- busy  output  1  router cannot accept `data_in` this cycle.
- error  output  1  parity mismatch on the last routed packet.

Behaviour:
- Packet format:
  - Header: bits [1:0] = address (0, 1, 2; 3 = invalid), bits [7:2] = payload length 1..63.
  - Payload bytes follow the header.
  - The final byte is parity: XOR of the header and all payload bytes. It is presented with `pkt_valid` = 0.
- Handshake: a byte is consumed on any posedge where `busy` = 0. The source holds `data_in` and `pkt_valid` stable while `busy` = 1.
- FSM states are DECODE, LOAD, DROP and CHECK. Reset state is DECODE.
- DECODE:
  - With `pkt_valid` = 1 and address < 3: if FIFO[addr] is empty, write the header, latch addr, set running parity = header, go to LOAD. Otherwise `busy` = 1 and stay in DECODE (wait until empty).
  - With `pkt_valid` = 1 and address = 3: consume the header, go to DROP.
- LOAD:
  - Each consumed byte is written to FIFO[addr]. While `pkt_valid` = 1, the byte is XORed into running parity.
  - When a byte is consumed with `pkt_valid` = 0, it is the parity byte: write it to the FIFO, latch it, go to CHECK.
- DROP: consume and discard bytes; after consuming a byte with `pkt_valid` = 0, return to DECODE. `error` is not affected.
- CHECK: lasts one cycle with `busy` = 1. `error` <= (running parity != received parity). Then go to DECODE.
- `busy` is combinational: (DECODE & `pkt_valid` & addr<3 & !empty[addr]) | (LOAD & full[addr]) | CHECK.
- `error` is registered. It holds its value until the next CHECK cycle or reset.
- FIFOs:
  - Each entry is 8 bits, with separate read/write pointers plus a count.
  - Simultaneous read and write are allowed in any state, including full; the count is unchanged.
  - A write when full never occurs because `busy` blocks it.
  - A read when empty is ignored; `data_out` holds its value.
- Read: on posedge with `read_enb_x` & !empty, `data_out_x` <= head entry and the pointer advances. `data_out_x` holds otherwise, so read latency is 1 cycle.
- `valid_out_x` = !empty_x (combinational).
- Soft reset:
  - Per-FIFO counter increments each cycle that `valid_out_x` = 1 and `read_enb_x` = 0. It clears when `read_enb_x` = 1 or the FIFO is empty.
  - When the counter reaches TIMEOUT, FIFO x is flushed next edge: pointers and count become 0, `data_out_x` becomes 0, counter clears.
  - The flush has priority over a same-cycle write; that byte is lost, and the FSM continues normally.
- Reset: FSM = DECODE, all FIFOs empty, all `data_out` = 0, all `valid_out` = 0, `error` = 0, counters = 0.
- Reset mid-packet aborts the packet; the sender must restart with a header.

Test Plan:
- Route to port 1: header 0x09, payload 0xA5, 0x3C, parity 0x90 (`pkt_valid` low) -> `valid_out_1` = 1, `read_enb_1` yields 09, A5, 3C, 90 on consecutive cycles, `error` = 0, `busy` = 1 only during CHECK.
- Bad parity: same packet to port 2 (header 0x0A, parity sent 0x00 instead of 0x93) -> `error` = 1 after CHECK, stays 1 until the next good packet clears it.
- Backpressure: port 0 packet with 20 payload bytes, no reads -> `busy` rises when FIFO 0 holds 16 entries; asserting `read_enb_0` drops `busy`, and all 22 bytes arrive in order.
- Destination busy: second packet to port 0 while FIFO 0 is non-empty -> `busy` = 1 in DECODE until the FIFO drains, then the header is accepted.
- Timeout: packet to port 2, `read_enb_2` held low -> `valid_out_2` falls 30-31 cycles after becoming valid; a later read returns a fresh packet only.
- Invalid address: header 0x07 plus 1 payload byte plus parity -> no FIFO written, all `valid_out` remain 0, `error` unchanged; async reset mid-packet returns all outputs to 0 immediately.

Source files
------------

// File: rtl/router_1x3.sv
// 1x3 byte-serial packet router: header-addressed steering into three FIFOs with parity check.
// Read data appears 1 cycle after read_enb; busy stalls the source on a full/occupied target FIFO and for the check cycle.

module router_1x3_fifo #(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr,
  input  logic [7:0] wr_data,
  input  logic       rd,
  output logic [7:0] rd_data,
  output logic       empty,
  output logic       full
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [TW-1:0] IDLE_MAX = TW'(TIMEOUT);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic [TW-1:0] idle;
  logic          flush, do_wr, do_rd;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);
  assign flush = (idle == IDLE_MAX);
  // A flush wins over a write arriving on the same edge; that byte is dropped.
  assign do_wr = wr & ~flush & ~full;
  assign do_rd = rd & ~empty;

  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      rd_data <= '0;
      idle    <= '0;
    end else if (flush) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      rd_data <= '0;
      idle    <= '0;
    end else begin
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) begin
        rptr    <= rptr + 1'b1;
        rd_data <= mem[rptr];
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (empty || rd) idle <= '0;
      else             idle <= idle + 1'b1;
    end
  end
endmodule

module router_1x3 #(
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pkt_valid,
  input  logic [7:0] data_in,
  input  logic       read_enb_0,
  input  logic       read_enb_1,
  input  logic       read_enb_2,
  output logic [7:0] data_out_0,
  output logic [7:0] data_out_1,
  output logic [7:0] data_out_2,
  output logic       valid_out_0,
  output logic       valid_out_1,
  output logic       valid_out_2,
  output logic       busy,
  output logic       error
);
  typedef enum logic [1:0] {DECODE, LOAD, DROP, CHECK} state_t;

  state_t     state, next_state;
  logic [1:0] addr, wr_sel;
  logic       wr_en;
  logic [7:0] parity, rx_parity;
  logic [2:0] wr, rd, empty, full;
  logic [3:0] empty_x, full_x;
  logic [7:0] rd_data [3];

  assign rd      = {read_enb_2, read_enb_1, read_enb_0};
  // Address 3 has no FIFO; pad so it can be indexed safely.
  assign empty_x = {1'b1, empty};
  assign full_x  = {1'b0, full};

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    wr_en      = 1'b0;
    wr_sel     = addr;
    case (state)
      DECODE: begin
        if (pkt_valid) begin
          if (data_in[1:0] == 2'd3) begin
            next_state = DROP;
          end else begin
            wr_sel = data_in[1:0];
            if (!empty_x[wr_sel]) begin
              busy = 1'b1;
            end else begin
              wr_en      = 1'b1;
              next_state = LOAD;
            end
          end
        end
      end
      LOAD: begin
        if (full_x[addr]) begin
          busy = 1'b1;
        end else begin
          wr_en = 1'b1;
          if (!pkt_valid) next_state = CHECK;
        end
      end
      DROP: begin
        if (!pkt_valid) next_state = DECODE;
      end
      CHECK: begin
        busy       = 1'b1;
        next_state = DECODE;
      end
      default: next_state = DECODE;
    endcase
  end

  assign wr = wr_en ? (3'b001 << wr_sel) : 3'b000;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= DECODE;
      addr      <= '0;
      parity    <= '0;
      rx_parity <= '0;
      error     <= 1'b0;
    end else begin
      state <= next_state;
      if (wr_en && state == DECODE) begin
        addr   <= wr_sel;
        parity <= data_in;
      end
      if (wr_en && state == LOAD) begin
        if (pkt_valid) parity    <= parity ^ data_in;
        else           rx_parity <= data_in;
      end
      if (state == CHECK) error <= (parity != rx_parity);
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_fifo
    router_1x3_fifo #(
      .DEPTH   (FIFO_DEPTH),
      .TIMEOUT (TIMEOUT)
    ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr      (wr[i]),
      .wr_data (data_in),
      .rd      (rd[i]),
      .rd_data (rd_data[i]),
      .empty   (empty[i]),
      .full    (full[i])
    );
  end

  assign data_out_0  = rd_data[0];
  assign data_out_1  = rd_data[1];
  assign data_out_2  = rd_data[2];
  assign valid_out_0 = ~empty[0];
  assign valid_out_1 = ~empty[1];
  assign valid_out_2 = ~empty[2];
endmodule

// File: tb/tb_router_1x3.sv
// Directed self-checking bench for router_1x3; inputs driven and outputs sampled just after the falling edge.
module tb_router_1x3;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       pkt_valid = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [2:0] rd_en = 3'b000;
  logic [7:0] data_out_0, data_out_1, data_out_2;
  logic       valid_out_0, valid_out_1, valid_out_2, busy, error;

  logic [2:0] vld;
  logic [7:0] dout [3];
  logic [7:0] got [$];
  logic [7:0] exp [$];
  int total = 0;
  int passed = 0;
  int stall_cycles = 0;
  int drain_cycles = 0;

  assign vld     = {valid_out_2, valid_out_1, valid_out_0};
  assign dout[0] = data_out_0;
  assign dout[1] = data_out_1;
  assign dout[2] = data_out_2;

  router_1x3 dut (
    .clk(clk), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
    .read_enb_0(rd_en[0]), .read_enb_1(rd_en[1]), .read_enb_2(rd_en[2]),
    .data_out_0(data_out_0), .data_out_1(data_out_1), .data_out_2(data_out_2),
    .valid_out_0(valid_out_0), .valid_out_1(valid_out_1), .valid_out_2(valid_out_2),
    .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  // Presents one byte and waits (bounded) until it is consumed.
  task automatic send_byte(input logic v, input logic [7:0] d);
    int c;
    pkt_valid = v;
    data_in   = d;
    #1;
    c = 0;
    while (busy === 1'b1 && c < 100) begin
      @(negedge clk); #2;
      c++;
      stall_cycles++;
    end
    if (busy !== 1'b0) begin
      total++;
      $display("FAIL send_byte_timeout: busy=%b required 0 for byte %h", busy, d);
    end
    @(negedge clk); #1;
  endtask

  task automatic drain(input int port, input int n);
    logic fire;
    got.delete();
    drain_cycles = 0;
    rd_en[port] = 1'b1;
    while (got.size() < n && drain_cycles < 200) begin
      fire = vld[port];
      @(negedge clk); #1;
      drain_cycles++;
      if (fire) got.push_back(dout[port]);
    end
    rd_en[port] = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk); #1;
    total++; if (vld !== 3'b000) $display("FAIL reset_valid: got %b required 000", vld); else passed++;
    total++; if ({data_out_0, data_out_1, data_out_2} !== 24'h0) $display("FAIL reset_data: got %h required 000000", {data_out_0, data_out_1, data_out_2}); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", busy); else passed++;
    total++; if (error !== 1'b0) $display("FAIL reset_error: got %b required 0", error); else passed++;
  endtask

  task automatic test_route_port1();
    logic bad;
    stall_cycles = 0;
    send_byte(1'b1, 8'h09);
    total++; if (valid_out_1 !== 1'b1) $display("FAIL route_valid1: got %b required 1", valid_out_1); else passed++;
    total++; if ({valid_out_2, valid_out_0} !== 2'b00) $display("FAIL route_other_valid: got %b required 00", {valid_out_2, valid_out_0}); else passed++;
    send_byte(1'b1, 8'hA5);
    send_byte(1'b1, 8'h3C);
    send_byte(1'b0, 8'h90);
    total++; if (stall_cycles != 0) $display("FAIL route_no_stall: got %0d stall cycles required 0", stall_cycles); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL route_busy_check: got %b required 1", busy); else passed++;
    @(negedge clk); #1;
    total++; if (busy !== 1'b0) $display("FAIL route_busy_after: got %b required 0", busy); else passed++;
    total++; if (error !== 1'b0) $display("FAIL route_error: got %b required 0", error); else passed++;
    drain(1, 4);
    exp = '{8'h09, 8'hA5, 8'h3C, 8'h90};
    bad = (got.size() != exp.size());
    for (int i = 0; i < got.size() && i < exp.size(); i++) if (got[i] !== exp[i]) bad = 1'b1;
    total++; if (bad) $display("FAIL route_data: got %0d bytes first %h required %0d bytes first %h", got.size(), (got.size() > 0) ? got[0] : 8'hxx, exp.size(), exp[0]); else passed++;
    total++; if (drain_cycles != 4) $display("FAIL route_consecutive: got %0d cycles required 4", drain_cycles); else passed++;
    total++; if (valid_out_1 !== 1'b0) $display("FAIL route_empty: got %b required 0", valid_out_1); else passed++;
  endtask

  task automatic test_bad_parity();
    logic bad;
    send_byte(1'b1, 8'h0A);
    send_byte(1'b1, 8'hA5);
    send_byte(1'b1, 8'h3C);
    send_byte(1'b0, 8'h00);
    @(negedge clk); #1;
    total++; if (error !== 1'b1) $display("FAIL badpar_error: got %b required 1", error); else passed++;
    drain(2, 4);
    exp = '{8'h0A, 8'hA5, 8'h3C, 8'h00};
    bad = (got.size() != exp.size());
    for (int i = 0; i < got.size() && i < exp.size(); i++) if (got[i] !== exp[i]) bad = 1'b1;
    total++; if (bad) $display("FAIL badpar_data: got %0d bytes required %0d bytes 0A A5 3C 00", got.size(), exp.size()); else passed++;
    repeat (5) @(negedge clk);
    #1;
    total++; if (error !== 1'b1) $display("FAIL badpar_hold: got %b required 1", error); else passed++;
    send_byte(1'b1, 8'h09);
    send_byte(1'b1, 8'hA5);
    send_byte(1'b1, 8'h3C);
    send_byte(1'b0, 8'h90);
    @(negedge clk); #1;
    total++; if (error !== 1'b0) $display("FAIL badpar_clear: got %b required 0", error); else passed++;
    drain(1, 4);
  endtask

  task automatic test_backpressure();
    logic [7:0] p [20];
    logic [7:0] par;
    logic bad;
    par = 8'h50;
    exp.delete();
    exp.push_back(8'h50);
    for (int i = 0; i < 20; i++) begin
      p[i] = 8'h10 + 8'(i);
      par  = par ^ p[i];
      exp.push_back(p[i]);
    end
    exp.push_back(par);
    send_byte(1'b1, 8'h50);
    for (int i = 0; i < 15; i++) send_byte(1'b1, p[i]);
    pkt_valid = 1'b1;
    data_in   = p[15];
    #1;
    total++; if (busy !== 1'b1) $display("FAIL bp_busy_full: got %b required 1", busy); else passed++;
    @(negedge clk); #1;
    total++; if (busy !== 1'b1) $display("FAIL bp_busy_hold: got %b required 1", busy); else passed++;
    fork
      begin
        for (int i = 15; i < 20; i++) send_byte(1'b1, p[i]);
        send_byte(1'b0, par);
      end
      drain(0, 22);
    join
    bad = (got.size() != exp.size());
    for (int i = 0; i < got.size() && i < exp.size(); i++) if (got[i] !== exp[i]) bad = 1'b1;
    total++; if (bad) $display("FAIL bp_order: got %0d bytes required %0d in order", got.size(), exp.size()); else passed++;
    total++; if (error !== 1'b0) $display("FAIL bp_error: got %b required 0", error); else passed++;
  endtask

  task automatic test_dest_busy();
    logic bad;
    send_byte(1'b1, 8'h04);
    send_byte(1'b1, 8'h77);
    send_byte(1'b0, 8'h73);
    pkt_valid = 1'b1;
    data_in   = 8'h08;
    @(negedge clk); #1;
    @(negedge clk); #1;
    total++; if (busy !== 1'b1) $display("FAIL dbusy_wait: got %b required 1", busy); else passed++;
    drain(0, 3);
    exp = '{8'h04, 8'h77, 8'h73};
    bad = (got.size() != exp.size());
    for (int i = 0; i < got.size() && i < exp.size(); i++) if (got[i] !== exp[i]) bad = 1'b1;
    total++; if (bad) $display("FAIL dbusy_first: got %0d bytes required 3 (04 77 73)", got.size()); else passed++;
    #1;
    total++; if (busy !== 1'b0) $display("FAIL dbusy_release: got %b required 0", busy); else passed++;
    @(negedge clk); #1;
    total++; if (valid_out_0 !== 1'b1) $display("FAIL dbusy_hdr: got %b required 1", valid_out_0); else passed++;
    send_byte(1'b1, 8'h11);
    send_byte(1'b1, 8'h22);
    send_byte(1'b0, 8'h3B);
    drain(0, 4);
    exp = '{8'h08, 8'h11, 8'h22, 8'h3B};
    bad = (got.size() != exp.size());
    for (int i = 0; i < got.size() && i < exp.size(); i++) if (got[i] !== exp[i]) bad = 1'b1;
    total++; if (bad) $display("FAIL dbusy_second: got %0d bytes required 4 (08 11 22 3B)", got.size()); else passed++;
  endtask

  task automatic test_timeout();
    time t0;
    int c, cyc;
    logic bad;
    send_byte(1'b1, 8'h06);
    t0 = $time;
    send_byte(1'b1, 8'h5A);
    send_byte(1'b0, 8'h5C);
    total++; if (valid_out_2 !== 1'b1) $display("FAIL to_valid: got %b required 1", valid_out_2); else passed++;
    c = 0;
    while (valid_out_2 === 1'b1 && c < 60) begin @(negedge clk); #1; c++; end
    cyc = int'(($time - t0) / 10);
    total++; if (cyc < 30 || cyc > 31) $display("FAIL to_timing: got %0d cycles required 30..31", cyc); else passed++;
    send_byte(1'b1, 8'h06);
    send_byte(1'b1, 8'h5A);
    send_byte(1'b0, 8'h5C);
    drain(2, 1);
    total++; if (data_out_2 !== 8'h06) $display("FAIL to_read1: got %h required 06", data_out_2); else passed++;
    c = 0;
    while (valid_out_2 === 1'b1 && c < 60) begin @(negedge clk); #1; c++; end
    total++; if ({valid_out_2, data_out_2} !== 9'h000) $display("FAIL to_flush: got valid %b data %h required 0 00", valid_out_2, data_out_2); else passed++;
    send_byte(1'b1, 8'h0A);
    send_byte(1'b1, 8'hC1);
    send_byte(1'b1, 8'hC2);
    send_byte(1'b0, 8'h09);
    drain(2, 4);
    exp = '{8'h0A, 8'hC1, 8'hC2, 8'h09};
    bad = (got.size() != exp.size());
    for (int i = 0; i < got.size() && i < exp.size(); i++) if (got[i] !== exp[i]) bad = 1'b1;
    total++; if (bad) $display("FAIL to_fresh: got %0d bytes required 4 (0A C1 C2 09)", got.size()); else passed++;
    total++; if (valid_out_2 !== 1'b0) $display("FAIL to_no_stale: got %b required 0", valid_out_2); else passed++;
  endtask

  task automatic test_invalid_addr();
    logic bad;
    send_byte(1'b1, 8'h09);
    send_byte(1'b1, 8'hA5);
    send_byte(1'b1, 8'h3C);
    send_byte(1'b0, 8'hFF);
    @(negedge clk); #1;
    drain(1, 4);
    total++; if (error !== 1'b1) $display("FAIL inv_pre_error: got %b required 1", error); else passed++;
    stall_cycles = 0;
    send_byte(1'b1, 8'h07);
    send_byte(1'b1, 8'h12);
    send_byte(1'b0, 8'h15);
    repeat (2) @(negedge clk);
    #1;
    total++; if (vld !== 3'b000) $display("FAIL inv_no_write: got %b required 000", vld); else passed++;
    total++; if (error !== 1'b1) $display("FAIL inv_error_kept: got %b required 1", error); else passed++;
    total++; if (stall_cycles != 0) $display("FAIL inv_no_stall: got %0d required 0", stall_cycles); else passed++;
    send_byte(1'b1, 8'h08);
    send_byte(1'b1, 8'h11);
    reset = 1'b0;
    #1;
    total++; if (vld !== 3'b000) $display("FAIL rst_mid_valid: got %b required 000", vld); else passed++;
    total++; if ({data_out_0, data_out_1, data_out_2} !== 24'h0) $display("FAIL rst_mid_data: got %h required 000000", {data_out_0, data_out_1, data_out_2}); else passed++;
    total++; if ({busy, error} !== 2'b00) $display("FAIL rst_mid_flags: got %b required 00", {busy, error}); else passed++;
    pkt_valid = 1'b0;
    @(negedge clk); #1;
    reset = 1'b1;
    @(negedge clk); #1;
    send_byte(1'b1, 8'h04);
    send_byte(1'b1, 8'h77);
    send_byte(1'b0, 8'h73);
    @(negedge clk); #1;
    drain(0, 3);
    exp = '{8'h04, 8'h77, 8'h73};
    bad = (got.size() != exp.size());
    for (int i = 0; i < got.size() && i < exp.size(); i++) if (got[i] !== exp[i]) bad = 1'b1;
    total++; if (bad) $display("FAIL rst_restart: got %0d bytes required 3 (04 77 73)", got.size()); else passed++;
    total++; if (error !== 1'b0) $display("FAIL rst_restart_error: got %b required 0", error); else passed++;
  endtask

  initial begin
    test_reset();
    test_route_port1();
    test_bad_parity();
    test_backpressure();
    test_dest_busy();
    test_timeout();
    test_invalid_addr();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, total);
    $fatal(1);
  end
endmodule
